// File: rtl/median_filter_stream_pkg.sv
// -----------------------------------------------------------------------------
// median_filter_pkg: shared state enum, counter-width helper, default length.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package median_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int C_LEN_DEFAULT = 8533;

  // Counter must be able to hold LEN itself, not just LEN-1.
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/median_filter_stream_if.sv
// -----------------------------------------------------------------------------
// median_filter_stream_if: control, input stream and output stream of the filter.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface median_filter_stream_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;

  modport master (
    output start, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, done
  );

  modport slave (
    input  start, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, done
  );
endinterface

`default_nettype wire

// File: rtl/median_filter_stream_median3_sort.sv
// -----------------------------------------------------------------------------
// median3_sort: combinational median of three; MEDIAN_FILTER_SIGNED_EN selects
// two's-complement compare. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module median3_sort
  import median_filter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] med
);

  logic ab_gt;
  logic ac_gt;
  logic bc_gt;

`ifdef MEDIAN_FILTER_SIGNED_EN
  assign ab_gt = $signed(a) > $signed(b);
  assign ac_gt = $signed(a) > $signed(c);
  assign bc_gt = $signed(b) > $signed(c);
`else
  assign ab_gt = a > b;
  assign ac_gt = a > c;
  assign bc_gt = b > c;
`endif

  // a sits between b and c when it beats exactly one of them; otherwise b
  // does when the a/b and b/c orderings agree, else c is the middle value.
  always_comb begin
    med = c;
    if (ab_gt != ac_gt) begin
      med = a;
    end else if (ab_gt == bc_gt) begin
      med = b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/median_filter_stream.sv
// -----------------------------------------------------------------------------
// median_filter_stream: streaming 3-tap median with edge replication, LEN samples
// per start. Optional macro MEDIAN_FILTER_SIGNED_EN (signed compare). Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module median_filter_stream
  import median_filter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = C_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  median_filter_stream_if.slave  bus
);

  localparam int              CNT_W      = cnt_width(LEN);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LEN - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               slot_free;
  logic               in_ready;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   med_c;
  logic [WIDTH-1:0]   med;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q == RUN) && slot_free;
  assign accept    = bus.in_valid && in_ready;

  // In DRAIN the missing right neighbour is the replicated last sample.
  assign med_c = (state_q == DRAIN) ? cur_q : bus.in_data;

  median3_sort #(
    .WIDTH (WIDTH)
  ) u_median3_sort (
    .a   (prev_q),
    .b   (cur_q),
    .c   (med_c),
    .med (med)
  );

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          cur_d = bus.in_data;
          // First sample fills both taps so the left edge is replicated.
          if (cnt_q == '0) begin
            prev_d = bus.in_data;
          end else begin
            prev_d = cur_q;
            load   = 1'b1;
          end
          if (cnt_q == C_CNT_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = med;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = (state_q == DONE) && !out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_median_filter_stream.sv
// -----------------------------------------------------------------------------
// tb_median_filter_stream: drives several filter instances (LEN 5,1,4,8,3) and
// checks outputs against a sort-based median model. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_median_filter_stream;
  import median_filter_pkg::*;

  localparam int N_DUT = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  int         sel;

  logic [7:0] dut_out_data  [N_DUT];
  logic       dut_out_valid [N_DUT];
  logic       dut_in_ready  [N_DUT];
  logic       dut_done      [N_DUT];

  logic [7:0] o_data;
  logic       o_valid;
  logic       o_in_ready;
  logic       o_done;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_checks;
  int         n_pass;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 5 : (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 8 : 3;
    median_filter_stream_if #(.WIDTH(8)) bus ();
    assign bus.start     = start && (sel == g);
    assign bus.in_valid  = in_valid && (sel == g);
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;
    assign dut_out_data[g]  = bus.out_data;
    assign dut_out_valid[g] = bus.out_valid;
    assign dut_in_ready[g]  = bus.in_ready;
    assign dut_done[g]      = bus.done;
    median_filter_stream #(.WIDTH(8), .LEN(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  always_comb begin
    o_data = '0; o_valid = 1'b0; o_in_ready = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin o_data = dut_out_data[0]; o_valid = dut_out_valid[0]; o_in_ready = dut_in_ready[0]; o_done = dut_done[0]; end
      1: begin o_data = dut_out_data[1]; o_valid = dut_out_valid[1]; o_in_ready = dut_in_ready[1]; o_done = dut_done[1]; end
      2: begin o_data = dut_out_data[2]; o_valid = dut_out_valid[2]; o_in_ready = dut_in_ready[2]; o_done = dut_done[2]; end
      3: begin o_data = dut_out_data[3]; o_valid = dut_out_valid[3]; o_in_ready = dut_in_ready[3]; o_done = dut_done[3]; end
      4: begin o_data = dut_out_data[4]; o_valid = dut_out_valid[4]; o_in_ready = dut_in_ready[4]; o_done = dut_done[4]; end
      default: ;
    endcase
  end

  // Reference median: sort the three samples by numeric value, take the middle.
  function automatic int key(input logic [7:0] v);
`ifdef MEDIAN_FILTER_SIGNED_EN
    return int'($signed(v));
`else
    return int'({24'd0, v});
`endif
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v[3];
    logic [7:0] t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 2; i++) begin
        if (key(v[i]) > key(v[i+1])) begin
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
        end
      end
    end
    return v[1];
  endfunction

  task automatic build_exp();
    int n;
    n = stim_q.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(med3(stim_q[(i > 0) ? i - 1 : 0], stim_q[i], stim_q[(i < n - 1) ? i + 1 : n - 1]));
    end
  endtask

  // mode: 0 sink always ready, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic run_txn(input int len, input int mode, input bit rand_valid,
                         input bit poke_start, output int cycles);
    int   idx;
    int   nout;
    int   cyc;
    bit   stall_prev;
    bit   in_fire;
    logic [7:0] held;
    build_exp();
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (o_done !== 1'b0) $display("FAIL done_fall: got %b expected 0", o_done);
    else n_pass++;
    idx = 0; nout = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (nout < len && cyc < 200) begin
      in_valid = (idx < len) && (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data  = (idx < len) ? stim_q[idx] : 8'($urandom);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = poke_start && (cyc == 2);
      @(negedge clk);
      if (cyc == 0) begin
        n_checks++;
        if (o_in_ready !== 1'b1) $display("FAIL first_in_ready: got %b expected 1", o_in_ready);
        else n_pass++;
      end
      if (stall_prev) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== held)
          $display("FAIL stall_hold: got valid=%b data=%0h expected valid=1 data=%0h", o_valid, o_data, held);
        else n_pass++;
      end
      if (o_valid && !out_ready) begin
        n_checks++;
        if (o_in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", o_in_ready);
        else n_pass++;
      end
      n_checks++;
      if (o_done !== 1'b0) $display("FAIL done_early: got %b expected 0 (cycle %0d)", o_done, cyc);
      else n_pass++;
      in_fire = in_valid && o_in_ready;
      if (o_valid && out_ready) begin
        n_checks++;
        if (o_data !== exp_q[nout]) $display("FAIL out_data[%0d]: got %0h expected %0h", nout, o_data, exp_q[nout]);
        else n_pass++;
        got_q.push_back(o_data);
        nout++;
      end
      stall_prev = o_valid && !out_ready;
      held = o_data;
      @(posedge clk); #1;
      if (in_fire) idx++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    cycles = cyc;
    n_checks++;
    if (nout != len) $display("FAIL txn_timeout: got %0d outputs expected %0d", nout, len);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL done_rise: got done=%b valid=%b expected done=1 valid=0", o_done, o_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < N_DUT; s++) begin
      sel = s;
      #1;
      n_checks++;
      if ({o_valid, o_in_ready, o_done, o_data} !== 11'd0)
        $display("FAIL reset_state[%0d]: got v=%b r=%b d=%b data=%0h expected all 0", s, o_valid, o_in_ready, o_done, o_data);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] want[5];
    int cyc;
    want = '{8'd3, 8'd3, 8'd7, 8'd7, 8'd7};
    sel = 0;
    stim_q = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd7};
    run_txn(5, 0, 1'b0, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) $display("FAIL basic_out[%0d]: got %0h expected %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]);
      else n_pass++;
    end
    n_checks++;
    if (cyc != 7) $display("FAIL basic_throughput: got %0d cycles expected 7", cyc);
    else n_pass++;
  endtask

  task automatic test_len1();
    int cyc;
    sel = 1;
    stim_q = '{8'd42};
    run_txn(1, 0, 1'b0, 1'b0, cyc);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'd42) $display("FAIL len1_out: got size=%0d expected one output 42", got_q.size());
    else n_pass++;
    n_checks++;
    if (cyc != 3) $display("FAIL len1_latency: got %0d cycles expected 3", cyc);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] want[4];
    int cyc;
    want = '{8'd10, 8'd20, 8'd30, 8'd40};
    sel = 2;
    stim_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_txn(4, 1, 1'b0, 1'b0, cyc);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) $display("FAIL stall_out[%0d]: got %0h expected %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    logic [7:0] want[3];
    int cyc;
`ifdef MEDIAN_FILTER_SIGNED_EN
    want = '{8'hFF, 8'hFF, 8'h80};
`else
    want = '{8'hFF, 8'h80, 8'h80};
`endif
    sel = 4;
    stim_q = '{8'hFF, 8'h01, 8'h80};
    run_txn(3, 0, 1'b0, 1'b0, cyc);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) $display("FAIL signed_out[%0d]: got %0h expected %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    sel = 3;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", o_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_in_ready, o_done, o_data} !== 11'd0)
      $display("FAIL async_reset: got v=%b r=%b d=%b data=%0h expected all 0", o_valid, o_in_ready, o_done, o_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    run_txn(8, 2, 1'b1, 1'b0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 3;
    for (int t = 0; t < 4; t++) begin
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
      run_txn(8, (t == 0) ? 0 : 2, t != 0, t == 1, cyc);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    sel = 0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_len1();
    test_stall();
    test_signed();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
